edge_decoder: RTL and testbench



---
 rtl/edge_decoder.sv | 152 +++++++++++++++
 tb/tb_edge_decoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_decoder.sv
// -----------------------------------------------------------------------------
// edge_decoder
//
// Rebuilds per-sample channel levels from a stream of edge records read back
// from capture memory. Each record toggles the channels selected by its edge
// mask, then presents the resulting level for in_count+1 samples.
//
// Ports
//   clk         sample/readout clock
//   nreset      asynchronous active-low reset
//   en          global enable; low freezes every register and drops in_ready
//   init_load   load init_value as the current level (only while IDLE)
//   init_value  starting level of the captured waveform
//   in_valid    edge record valid
//   in_ready    edge record accepted when in_valid & in_ready
//   in_edges    toggle mask applied on the record's first sample
//   in_count    extra repeat count (0 = one sample)
//   out_valid   reconstructed sample valid
//   out_ready   downstream accepts the sample
//   out_level   reconstructed channel level
//   out_edge    in_edges on a record's first sample, otherwise 0
//   sample_idx  index of the sample on out_level (only with the macro below)
//
// Build option
//   EDGE_DECODER_SAMPLE_IDX_EN  adds the 32-bit sample_idx output/counter.
// -----------------------------------------------------------------------------
module edge_decoder #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          init_load,
    input  logic [N-1:0]  init_value,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_edges,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_level,
    output logic [N-1:0]  out_edge
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
    ,
    output logic [31:0]   sample_idx
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  lvl_q, lvl_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  edge_q, edge_d;

    logic          accept;
    logic          init_take;
    logic [N-1:0]  base_lvl;

    // Ready may rise combinationally from out_ready so the next record can be
    // taken on the same edge the last repeat of the current one is consumed.
    assign in_ready  = en & ((state_q == IDLE) |
                             ((state_q == EXPAND) & (rem_q == '0) & out_ready));
    assign accept    = in_valid & in_ready;
    assign init_take = en & init_load & (state_q == IDLE);
    // A same-cycle init_load takes effect before the record's toggle mask.
    assign base_lvl  = init_take ? init_value : lvl_q;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        rem_d   = rem_q;
        level_d = level_q;
        edge_d  = edge_q;

        if (en) begin
            if (init_take) begin
                lvl_d = init_value;
            end

            if ((state_q == EXPAND) && out_ready) begin
                edge_d = '0;
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else if (!accept) begin
                    state_d = IDLE;
                end
            end

            // Accept in EXPAND only happens when rem==0 and the sample is
            // consumed, so this load cleanly replaces the finishing record.
            if (accept) begin
                lvl_d   = base_lvl ^ in_edges;
                level_d = base_lvl ^ in_edges;
                edge_d  = in_edges;
                rem_d   = in_count;
                state_d = EXPAND;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            rem_q   <= '0;
            level_q <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            rem_q   <= rem_d;
            level_q <= level_d;
            edge_q  <= edge_d;
        end
    end

    assign out_valid = (state_q == EXPAND);
    assign out_level = level_q;
    assign out_edge  = edge_q;

`ifdef EDGE_DECODER_SAMPLE_IDX_EN
    logic [31:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (en) begin
            if (init_take) begin
                idx_d = '0;
            end else if (out_valid && out_ready) begin
                idx_d = idx_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign sample_idx = idx_q;
`endif

endmodule

// File: tb/tb_edge_decoder.sv
// -----------------------------------------------------------------------------
// tb_edge_decoder
//
// Self-checking bench for edge_decoder (N=4, CW=8). A queue-based reference
// model expands every accepted record into its list of expected samples; the
// DUT outputs are compared against the head of that list each cycle.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_edge_decoder;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk        = 1'b0;
    logic          nreset     = 1'b1;
    logic          en         = 1'b1;
    logic          init_load  = 1'b0;
    logic [N-1:0]  init_value = '0;
    logic          in_valid   = 1'b0;
    logic [N-1:0]  in_edges   = '0;
    logic [CW-1:0] in_count   = '0;
    logic          out_ready  = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_level;
    logic [N-1:0]  out_edge;
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
    logic [31:0]   sample_idx;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] edg;
    } samp_t;

    // Reference model state: pending samples (head = sample on the outputs).
    samp_t        q[$];
    logic [N-1:0] m_lvl = '0;
    logic [N-1:0] m_out = '0;
    logic [31:0]  m_idx = '0;

    logic         e_valid;
    logic         e_ready;
    logic [N-1:0] e_level;
    logic [N-1:0] e_edge;

    edge_decoder #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .en         (en),
        .init_load  (init_load),
        .init_value (init_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_edges   (in_edges),
        .in_count   (in_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_level  (out_level),
        .out_edge   (out_edge)
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
        ,
        .sample_idx (sample_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_lvl = '0;
        m_out = '0;
        m_idx = '0;
    endtask

    // Expected outputs for the current inputs, before the next rising edge.
    task automatic model_eval();
        e_valid = (q.size() > 0);
        e_level = e_valid ? q[0].lvl : m_out;
        e_edge  = e_valid ? q[0].edg : '0;
        e_ready = en && ((q.size() == 0) || ((q.size() == 1) && out_ready));
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_clock();
        logic [N-1:0] base;
        bit           idle;
        if (!en) return;
        idle = (q.size() == 0);
        base = m_lvl;
        if (idle && init_load) begin
            base  = init_value;
            m_lvl = init_value;
            m_idx = '0;
        end
        if (!idle && out_ready) begin
            m_out = q[0].lvl;
            void'(q.pop_front());
            m_idx = m_idx + 32'd1;
        end
        if (in_valid && e_ready) begin
            m_lvl = base ^ in_edges;
            for (int k = 0; k <= int'(in_count); k++) begin
                q.push_back(samp_t'{lvl: m_lvl, edg: (k == 0) ? in_edges : '0});
            end
        end
    endtask

    task automatic set_idle_inputs();
        en        = 1'b1;
        init_load = 1'b0;
        in_valid  = 1'b0;
        in_edges  = '0;
        in_count  = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        set_idle_inputs();
        #1 nreset = 1'b0;
        #2;
        model_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_level !== 4'b0000 || out_edge !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid/level/edge got %b/%b/%b want 0/0000/0000",
                     out_valid, out_level, out_edge);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
        tests_run++;
        if (sample_idx !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_sample_idx: got %0d want 0", sample_idx);
        end
`endif
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_init_record();
        for (int c = 0; c < 7; c++) begin
            set_idle_inputs();
            init_load  = (c == 0);
            init_value = 4'b0101;
            in_valid   = (c == 1);
            in_edges   = 4'b0011;
            in_count   = 8'd2;
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                tests_failed++;
                $display("FAIL init_record c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
            if (c == 2) begin
                tests_run++;
                if (out_level !== 4'b0110 || out_edge !== 4'b0011) begin
                    tests_failed++;
                    $display("FAIL init_first_sample: lvl/edg got %b/%b want 0110/0011",
                             out_level, out_edge);
                end
            end
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
            if (e_valid) begin
                tests_run++;
                if (sample_idx !== m_idx) begin
                    tests_failed++;
                    $display("FAIL init_record_idx c=%0d: got %0d want %0d", c, sample_idx, m_idx);
                end
            end
`endif
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            set_idle_inputs();
            init_load  = (c == 0);
            init_value = 4'b0000;
            in_valid   = (c == 1) || (c == 2);
            in_edges   = 4'b1000;
            in_count   = 8'd0;
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                tests_failed++;
                $display("FAIL back_to_back c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
            if (c == 2 || c == 3) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_edge !== 4'b1000 ||
                    out_level !== ((c == 2) ? 4'b1000 : 4'b0000) || (c == 2 && in_ready !== 1'b1)) begin
                    tests_failed++;
                    $display("FAIL b2b_no_bubble c=%0d: v/r/lvl/edg got %b/%b/%b/%b",
                             c, out_valid, in_ready, out_level, out_edge);
                end
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 14; c++) begin
            set_idle_inputs();
            in_valid  = (c == 0);
            in_edges  = 4'b0001;
            in_count  = 8'd3;
            out_ready = !(c >= 1 && c <= 5);
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                tests_failed++;
                $display("FAIL backpressure c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
            if (e_valid) begin
                tests_run++;
                if (sample_idx !== m_idx) begin
                    tests_failed++;
                    $display("FAIL backpressure_idx c=%0d: got %0d want %0d", c, sample_idx, m_idx);
                end
            end
`endif
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_max_count();
        int errs = 0;
        int seen = 0;
        for (int c = 0; c < 262; c++) begin
            set_idle_inputs();
            init_load  = (c == 0);
            init_value = 4'b0000;
            in_valid   = (c == 0);
            in_edges   = 4'b1111;
            in_count   = 8'd255;
            #1;
            model_eval();
            if (out_valid === 1'b1 && out_level === 4'b1111) seen++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                errs++;
                if (errs <= 3)
                    $display("FAIL max_count c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                             c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
            model_clock();
            @(negedge clk);
        end
        tests_run++;
        if (errs != 0) tests_failed++;
        tests_run++;
        if (seen != 256) begin
            tests_failed++;
            $display("FAIL max_count_samples: got %0d want 256", seen);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            set_idle_inputs();
            in_valid = (c == 0);
            in_edges = 4'b0010;
            in_count = 8'd10;
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                tests_failed++;
                $display("FAIL pre_reset c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
            model_clock();
            @(negedge clk);
        end
        #2 nreset = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_level !== 4'b0000 || out_edge !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset: valid/level/edge got %b/%b/%b want 0/0000/0000",
                     out_valid, out_level, out_edge);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_idle_inputs();
            in_valid = (c == 0);
            in_edges = 4'b0010;
            in_count = 8'd0;
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge ||
                (c == 1 && out_level !== 4'b0010)) begin
                tests_failed++;
                $display("FAIL post_reset c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_enable();
        for (int c = 0; c < 11; c++) begin
            set_idle_inputs();
            in_valid = (c == 0) || (c == 3);
            in_edges = 4'b0100;
            in_count = 8'd4;
            en       = !(c >= 2 && c <= 4);
            #1;
            model_eval();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                tests_failed++;
                $display("FAIL enable c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                         c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
            if (e_valid) begin
                tests_run++;
                if (sample_idx !== m_idx) begin
                    tests_failed++;
                    $display("FAIL enable_idx c=%0d: got %0d want %0d", c, sample_idx, m_idx);
                end
            end
`endif
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 600; c++) begin
            en         = ($urandom_range(0, 9) != 0);
            init_load  = ($urandom_range(0, 7) == 0);
            init_value = N'($urandom());
            in_valid   = ($urandom_range(0, 1) == 1);
            in_edges   = N'($urandom());
            in_count   = CW'($urandom_range(0, 4));
            out_ready  = ($urandom_range(0, 9) < 7);
            #1;
            model_eval();
            if (out_valid !== e_valid || in_ready !== e_ready ||
                out_level !== e_level || out_edge !== e_edge) begin
                errs++;
                if (errs <= 3)
                    $display("FAIL random c=%0d: v/r/lvl/edg got %b/%b/%b/%b want %b/%b/%b/%b",
                             c, out_valid, in_ready, out_level, out_edge, e_valid, e_ready, e_level, e_edge);
            end
`ifdef EDGE_DECODER_SAMPLE_IDX_EN
            if (e_valid && sample_idx !== m_idx) begin
                errs++;
                if (errs <= 3)
                    $display("FAIL random_idx c=%0d: got %0d want %0d", c, sample_idx, m_idx);
            end
`endif
            model_clock();
            @(negedge clk);
        end
        tests_run++;
        if (errs != 0) tests_failed++;
    endtask

    initial begin
        test_reset();
        test_init_record();
        test_back_to_back();
        test_backpressure();
        test_max_count();
        test_async_reset();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
